// File: rtl/rr_mux.sv
// Round-robin multiplexer: merges CHANNELS valid/ready word streams into one
// registered output stream tagged with the source channel. Optional packet lock: RR_MUX_PACKET_LOCK_EN.
module rr_mux #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
`ifdef RR_MUX_PACKET_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load;
  logic             grantValid;
  logic [SEL_W-1:0] grantIdx;
  logic [SEL_W-1:0] candIdx;
  logic             accept;
  logic             lockActive;

  assign load = !valid_q || out_ready;

  // Search starts one past the last grant; while locked only last_q may win.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = last_q;
    candIdx    = last_q;
    for (int k = 1; k <= CHANNELS; k++) begin
      candIdx = last_q + SEL_W'(k);
      if (!grantValid && in_valid[candIdx] && (!lockActive || candIdx == last_q)) begin
        grantValid = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  // No word is accepted while reset is held, since it would be discarded anyway.
  assign accept = load && grantValid && !reset;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = accept && (grantIdx == SEL_W'(i));
    end
  end

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      if (grantValid) begin
        data_d  = in_data[int'(grantIdx)*WIDTH +: WIDTH];
        sel_d   = grantIdx;
        valid_d = 1'b1;
        last_d  = grantIdx;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(CHANNELS - 1);
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

`ifdef RR_MUX_PACKET_LOCK_EN
  typedef enum logic {
    LOCK_FREE,
    LOCK_HELD
  } lockState_e;

  lockState_e state_q, state_d;
  logic       outLast_q, outLast_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOCK_FREE;
      outLast_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      outLast_q <= outLast_d;
    end
  end

  // The lock channel is always last_q, so only the state needs tracking.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOCK_FREE: if (accept && !in_last[grantIdx]) state_d = LOCK_HELD;
      LOCK_HELD: if (accept && in_last[grantIdx])  state_d = LOCK_FREE;
      default:   state_d = LOCK_FREE;
    endcase
  end

  always_comb begin
    lockActive = (state_q == LOCK_HELD);
    outLast_d  = outLast_q;
    if (load && grantValid) outLast_d = in_last[grantIdx];
  end

  assign out_last = outLast_q;
`else
  assign lockActive = 1'b0;
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux (4 channels, 16-bit words).
// The packet-lock scenario runs only when RR_MUX_PACKET_LOCK_EN is defined.
module tb_rr_mux;

   logic        clock;
   logic        reset;
   logic [63:0] inData;
   logic [3:0]  inValid;
   logic [3:0]  inReady;
   logic [15:0] outData;
   logic [1:0]  outSel;
   logic        outValid;
   logic        outReady;
`ifdef RR_MUX_PACKET_LOCK_EN
   logic [3:0]  inLast;
   logic        outLast;
`endif

   int checkCount;
   int failCount;

   rr_mux #(.WIDTH(16), .CHANNELS(4)) dut (
      .clk       (clock),
      .reset     (reset),
      .in_data   (inData),
      .in_valid  (inValid),
      .in_ready  (inReady),
`ifdef RR_MUX_PACKET_LOCK_EN
      .in_last   (inLast),
      .out_last  (outLast),
`endif
      .out_data  (outData),
      .out_sel   (outSel),
      .out_valid (outValid),
      .out_ready (outReady)
   );

   // Free-running 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive the per-channel valids and the downstream ready
   task automatic applyStimulus(input logic [3:0] valid, input logic ready);
      inValid  = valid;
      outReady = ready;
   endtask

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Main directed sequence
   initial begin
      checkCount = 0;
      failCount  = 0;
      reset      = 1'b1;
      inData     = '0;
      for (int i = 0; i < 4; i++) inData[i*16 +: 16] = 16'h00A0 + 16'(i);
`ifdef RR_MUX_PACKET_LOCK_EN
      inLast = 4'b0000;
`endif
      applyStimulus(4'b1111, 1'b1);
      step();
      step();
      checkOutput("rst_valid", 32'(outValid), 32'd0);
      checkOutput("rst_data",  32'(outData),  32'd0);
      checkOutput("rst_sel",   32'(outSel),   32'd0);
      checkOutput("rst_ready", 32'(inReady),  32'd0);

      reset = 1'b0;
      #1;
      checkOutput("first_ready", 32'(inReady), 32'b0001);

      for (int i = 0; i < 8; i++) begin
         step();
         checkOutput("rot_valid", 32'(outValid), 32'd1);
         checkOutput("rot_sel",   32'(outSel),   32'(i % 4));
         checkOutput("rot_data",  32'(outData),  32'h00A0 + 32'(i % 4));
      end

      applyStimulus(4'b1010, 1'b1);
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput("skip_ready", 32'(inReady), (k % 2 == 0) ? 32'b0010 : 32'b1000);
         step();
         checkOutput("skip_sel", 32'(outSel), (k % 2 == 0) ? 32'd1 : 32'd3);
      end

      inData[2*16 +: 16] = 16'hBEEF;
      applyStimulus(4'b0100, 1'b1);
      #1;
      checkOutput("bp_load_ready", 32'(inReady), 32'b0100);
      step();
      checkOutput("bp_data", 32'(outData), 32'hBEEF);
      checkOutput("bp_sel",  32'(outSel),  32'd2);
      inData[3*16 +: 16] = 16'hC0DE;
      applyStimulus(4'b1100, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checkOutput("bp_hold_ready", 32'(inReady), 32'd0);
         step();
         checkOutput("bp_hold_data",  32'(outData),  32'hBEEF);
         checkOutput("bp_hold_sel",   32'(outSel),   32'd2);
         checkOutput("bp_hold_valid", 32'(outValid), 32'd1);
      end
      applyStimulus(4'b1100, 1'b1);
      #1;
      checkOutput("bp_release_ready", 32'(inReady), 32'b1000);
      step();
      checkOutput("bp_next_data", 32'(outData), 32'hC0DE);
      checkOutput("bp_next_sel",  32'(outSel),  32'd3);

      applyStimulus(4'b0000, 1'b1);
      step();
      checkOutput("idle_valid", 32'(outValid), 32'd0);
      checkOutput("idle_data",  32'(outData),  32'hC0DE);

      inData[0 +: 16] = 16'h1234;
      applyStimulus(4'b0001, 1'b1);
      step();
      checkOutput("mid_data", 32'(outData), 32'h1234);
      applyStimulus(4'b0000, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 32'(outValid), 32'd0);
      checkOutput("mid_rst_data",  32'(outData),  32'd0);
      checkOutput("mid_rst_sel",   32'(outSel),   32'd0);
      step();
      reset = 1'b0;
      applyStimulus(4'b1110, 1'b1);
      step();
      checkOutput("post_rst_sel", 32'(outSel), 32'd1);

`ifdef RR_MUX_PACKET_LOCK_EN
      reset = 1'b1;
      step();
      reset = 1'b0;
      inLast = 4'b0000;
      applyStimulus(4'b0011, 1'b1);
      step();
      checkOutput("pkt_sel0",  32'(outSel),  32'd0);
      checkOutput("pkt_last0", 32'(outLast), 32'd0);
      step();
      checkOutput("pkt_sel1",  32'(outSel),  32'd0);
      checkOutput("pkt_last1", 32'(outLast), 32'd0);
      inLast = 4'b0001;
      step();
      checkOutput("pkt_sel2",  32'(outSel),  32'd0);
      checkOutput("pkt_last2", 32'(outLast), 32'd1);
      inLast = 4'b0000;
      step();
      checkOutput("pkt_sel3",  32'(outSel),  32'd1);
      checkOutput("pkt_last3", 32'(outLast), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
